// File: rtl/sprite_animator.sv
// N-frame sprite index stepper: loop, one-shot and hold modes with pause.
// Define SPRITE_ANIM_PINGPONG_EN to make LOOP bounce instead of wrap.
module sprite_animator #(
  parameter int FRAMES         = 2,
  parameter int FRAME_W        = 4,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 3000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               enable,
  input  logic [CNT_W-1:0]   period,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    LOOP,
    ONESHOT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0]   DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [FRAME_W-1:0] LAST  = FRAME_W'(FRAMES - 1);
  localparam logic [FRAME_W-1:0] ONE   = FRAME_W'(1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   per_q, per_n, per_sel;
  logic [FRAME_W-1:0] frame_n, loop_next;
  logic               tick_n, done_n, busy_n;
  logic               run, at_end, adv;

  assign per_sel = (period == '0) ? DEF_P : period;
  assign run     = !start && enable
                && (state == LOOP || state == ONESHOT);
  assign at_end  = (cnt == per_q - CNT_W'(1));
  assign adv     = run && at_end;

`ifdef SPRITE_ANIM_PINGPONG_EN
  // dir_q: 0 = counting up, 1 = counting down
  logic dir_q, dir_n, dir_loop;

  always_comb begin
    loop_next = frame + ONE;
    dir_loop  = dir_q;
    if (FRAMES <= 2) begin
      loop_next = (frame == LAST) ? '0 : frame + ONE;
    end else if (!dir_q) begin
      if (frame == LAST) begin
        loop_next = frame - ONE;
        dir_loop  = 1'b1;
      end
    end else if (frame == '0) begin
      loop_next = frame + ONE;
      dir_loop  = 1'b0;
    end else begin
      loop_next = frame - ONE;
    end
  end

  always_comb begin
    dir_n = dir_q;
    if (start) dir_n = 1'b0;
    else if (adv && state == LOOP) dir_n = dir_loop;
  end

  always_ff @(posedge clk) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_n;
  end
`else
  always_comb begin
    loop_next = (frame == LAST) ? '0 : frame + ONE;
  end
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per_q;
    frame_n = frame;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    unique case (1'b1)
      start: begin
        cnt_n   = '0;
        frame_n = '0;
        per_n   = per_sel;
        if (mode == 2'b01)      state_n = LOOP;
        else if (mode == 2'b10) state_n = ONESHOT;
        else                    state_n = IDLE;
      end
      run && !at_end: begin
        cnt_n = cnt + CNT_W'(1);
      end
      adv: begin
        cnt_n = '0;
        per_n = per_sel;
        if (state == ONESHOT && frame == LAST) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          tick_n  = 1'b1;
          frame_n = (state == ONESHOT) ? frame + ONE
                                       : loop_next;
        end
      end
      default: ;
    endcase
    busy_n = (state_n == LOOP) || (state_n == ONESHOT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      per_q      <= DEF_P;
      frame      <= '0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      per_q      <= per_n;
      frame      <= frame_n;
      frame_tick <= tick_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: FRAMES=4/2/1 instances checked against
// an advance-count model every cycle, plus directed literal checks.
module tb_sprite_animator;

  localparam int CW = 8;
  localparam int DP = 10;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          enable;
  logic [CW-1:0] period;

  logic [NI-1:0][3:0] fr;
  logic [NI-1:0]      tk, bs, dn;

  int checks = 0;
  int errors = 0;
  bit live   = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sprite_animator #(
      .FRAMES        (g == 0 ? 4 : (g == 1 ? 2 : 1)),
      .FRAME_W       (4),
      .CNT_W         (CW),
      .DEFAULT_PERIOD(DP)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .enable    (enable),
      .period    (period),
      .frame     (fr[g]),
      .frame_tick(tk[g]),
      .busy      (bs[g]),
      .done      (dn[g])
    );
  end

  function automatic int nfr(int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  // model: activity (0 idle,1 loop,2 oneshot,3 done), advances k,
  // elapsed cycles in frame, latched period
  int m_act[NI];
  int m_k[NI];
  int m_el[NI];
  int m_p[NI];
  bit m_tk[NI];
  bit m_dn[NI];
  int pv;

  function automatic int loopf(int k, int n);
    int m;
    m = k % n;
`ifdef SPRITE_ANIM_PINGPONG_EN
    if (n > 2) begin
      m = k % (2 * n - 2);
      if (m >= n) m = 2 * n - 2 - m;
    end
`endif
    return m;
  endfunction

  function automatic int m_frame(int i);
    case (m_act[i])
      1:       return loopf(m_k[i], nfr(i));
      2:       return m_k[i];
      3:       return nfr(i) - 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    pv = (period == 0) ? DP : int'(period);
    for (int i = 0; i < NI; i++) begin
      m_tk[i] = 1'b0;
      m_dn[i] = 1'b0;
      if (rst) begin
        m_act[i] = 0;
        m_k[i]   = 0;
        m_el[i]  = 0;
        m_p[i]   = DP;
      end else if (start) begin
        m_act[i] = (mode == 2'd1) ? 1 : ((mode == 2'd2) ? 2 : 0);
        m_k[i]   = 0;
        m_el[i]  = 0;
        m_p[i]   = pv;
      end else if ((m_act[i] == 1 || m_act[i] == 2) && enable) begin
        if (m_el[i] + 1 == m_p[i]) begin
          m_el[i] = 0;
          m_p[i]  = pv;
          if (m_act[i] == 2 && m_k[i] == nfr(i) - 1) begin
            m_act[i] = 3;
            m_dn[i]  = 1'b1;
          end else begin
            m_k[i]  = m_k[i] + 1;
            m_tk[i] = 1'b1;
          end
        end else begin
          m_el[i] = m_el[i] + 1;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("frame[%0d]", i), 32'(fr[i]), m_frame(i));
        chk($sformatf("tick[%0d]", i), 32'(tk[i]), 32'(m_tk[i]));
        chk($sformatf("busy[%0d]", i), 32'(bs[i]),
            32'(m_act[i] == 1 || m_act[i] == 2));
        chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_dn[i]));
      end
    end
  end

  task automatic lit(string nm, int i, int f, bit t);
    chk({nm, "_dut_f"}, 32'(fr[i]), f);
    chk({nm, "_mdl_f"}, m_frame(i), f);
    chk({nm, "_dut_t"}, 32'(tk[i]), 32'(t));
  endtask

  task automatic pulse_start(logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int seq[7];

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 2'd0;
    enable = 1'b1;
    period = '0;
    repeat (2) @(negedge clk);
    live = 1'b1;
    rst  = 1'b0;
    chk("rst_frame", 32'(fr[0]), 0);
    chk("rst_busy", 32'(bs[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_tick", 32'(tk[0]), 0);

    // default period, FRAMES=2 toggles every DP cycles
    pulse_start(2'd1);
    edges(9);  lit("def9", 1, 0, 0);
    edges(1);  lit("def10", 1, 1, 1);
    edges(1);  lit("def11", 1, 1, 0);
    edges(9);  lit("def20", 1, 0, 1);

    // loop wrap, FRAMES=4, period=3
    period = 8'd3;
    pulse_start(2'd1);
    edges(3);  lit("lp3", 0, 1, 1);
    chk("lp3_busy", 32'(bs[0]), 1);
    edges(3);  lit("lp6", 0, 2, 1);
    edges(3);  lit("lp9", 0, 3, 1);
    edges(3);  lit("lp12", 0, 0, 1);

    // one-shot, period=2
    period = 8'd2;
    pulse_start(2'd2);
    edges(2);  lit("os2", 0, 1, 1);
    chk("os2_f1_done", 32'(dn[2]), 1);
    edges(2);  lit("os4", 0, 2, 1);
    edges(2);  lit("os6", 0, 3, 1);
    edges(2);  lit("os8", 0, 3, 0);
    chk("os8_done", 32'(dn[0]), 1);
    chk("os8_busy", 32'(bs[0]), 0);
    edges(1);
    chk("os9_done", 32'(dn[0]), 0);

    // pause and mid-frame period change
    period = 8'd5;
    pulse_start(2'd1);
    edges(2);  enable = 1'b0;
    edges(3);  period = 8'd2;
    edges(4);  lit("pz9", 0, 0, 0);
    enable = 1'b1;
    edges(2);  lit("pz11", 0, 0, 0);
    edges(1);  lit("pz12", 0, 1, 1);
    edges(2);  lit("pz14", 0, 2, 1);
    edges(2);  lit("pz16", 0, 3, 1);

    // hold mode
    pulse_start(2'd0);
    edges(3);  lit("hold", 0, 0, 0);
    chk("hold_busy", 32'(bs[0]), 0);

    // rst together with start
    pulse_start(2'd1);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mode = 2'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rs_frame", 32'(fr[0]), 0);
    chk("rs_busy", 32'(bs[0]), 0);

    // start on the edge an advance would occur
    period = 8'd3;
    pulse_start(2'd1);
    edges(2);  start = 1'b1;
    edges(1);  start = 1'b0;
    lit("col3", 0, 0, 0);
    chk("col3_busy", 32'(bs[0]), 1);
    edges(3);  lit("col6", 0, 1, 1);

    // period=1 advances every edge
`ifdef SPRITE_ANIM_PINGPONG_EN
    seq = '{1, 2, 3, 2, 1, 0, 1};
`else
    seq = '{1, 2, 3, 0, 1, 2, 3};
`endif
    period = 8'd1;
    pulse_start(2'd1);
    for (int j = 0; j < 7; j++) begin
      edges(1);
      lit($sformatf("p1_%0d", j + 1), 0, seq[j], 1);
    end

    edges(3);
    live = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
